data_mem: RTL

- Data memory stage directly downstream of the ALU in the single-cycle MIPS datapath.
- Takes the ALU result as a byte address and the rt register value as store data.
- Performs word, halfword and byte stores on the clock edge.
- Returns combinational load data, zero- or sign-extended, to the register-file write-back mux.
- Flags misaligned, out-of-range and illegal accesses so the top level can trap or ignore them.

---
 rtl/data_mem.sv | 96 +++++++++
 1 files changed

// File: rtl/data_mem.sv
// Data memory for the single-cycle MIPS datapath: byte/half/word stores on the
// rising clock edge, combinational extended loads, and an access-fault flag.
module data_mem #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memwrite,
  input  logic [2:0]  memop,
  output logic [31:0] rdata,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    OP_WORD = 3'b000,
    OP_HU   = 3'b001,
    OP_HS   = 3'b010,
    OP_BU   = 3'b011,
    OP_BS   = 3'b100
  } memop_t;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       word;
  logic              is_word;
  logic              is_half;
  logic              is_byte;
  logic              out_of_range;
  logic [3:0]        byte_en;
  logic [31:0]       wlane;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;

  assign word_idx     = addr[ADDR_W+1:2];
  assign word         = mem[word_idx];
  assign is_word      = (memop == OP_WORD);
  assign is_half      = (memop == OP_HU) || (memop == OP_HS);
  assign is_byte      = (memop == OP_BU) || (memop == OP_BS);
  assign out_of_range = |addr[31:ADDR_W+2];

  // Reserved memop values fall through every size check and fault here.
  always_comb begin
    addr_err = out_of_range;
    if (is_word && (addr[1:0] != 2'b00)) addr_err = 1'b1;
    if (is_half && addr[0])              addr_err = 1'b1;
    if (!is_word && !is_half && !is_byte) addr_err = 1'b1;
  end

  always_comb begin
    byte_en = 4'b0000;
    wlane   = wdata;
    if (is_word) begin
      byte_en = 4'b1111;
    end else if (is_half) begin
      byte_en = addr[1] ? 4'b1100 : 4'b0011;
      wlane   = {wdata[15:0], wdata[15:0]};
    end else if (is_byte) begin
      byte_en = 4'b0001 << addr[1:0];
      wlane   = {4{wdata[7:0]}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i[ADDR_W-1:0]] <= '0;
      end
    end else if (memwrite && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign half_sel = addr[1] ? word[31:16] : word[15:0];
  assign byte_sel = word[8*addr[1:0] +: 8];

  always_comb begin
    rdata = '0;
    if (!addr_err) begin
      case (memop)
        OP_WORD: rdata = word;
        OP_HU:   rdata = {16'h0000, half_sel};
        OP_HS:   rdata = {{16{half_sel[15]}}, half_sel};
        OP_BU:   rdata = {24'h000000, byte_sel};
        OP_BS:   rdata = {{24{byte_sel[7]}}, byte_sel};
        default: rdata = '0;
      endcase
    end
  end

endmodule
